pll_cfg_ctrl: RTL and testbench
===============================

PLL_CFG_CTRL -- requirements
Module: pll_cfg_ctrl

Interface
REQ-001 SHALL have parameter K_NTSC, default 2537930535, meaning the fractional K word for the NTSC video mode (VCO 429.5454 MHz).
REQ-002 SHALL have parameter K_PAL, default 2201376897, meaning the fractional K word for the PAL video mode (VCO about 425.63 MHz).
REQ-003 SHALL have parameter LOCK_TMO, default 1048575, meaning the lock-wait timeout in refclk cycles (used only when the PLL_CFG_RETRY_EN macro is defined).
REQ-004 Ports, in this order:
- refclk  in  1  -- 50 MHz clock; the only clock.
- rst  in  1  -- synchronous, active-high reset.
- pal  in  1  -- requested mode (1 = PAL); asynchronous.
- pll_locked  in  1  -- PLL locked; asynchronous.
- cfg_waitrequest  in  1  -- reconfig slave stall.
- cfg_address  out  6  -- reconfig register address.
- cfg_write  out  1  -- write strobe.
- cfg_writedata  out  32  -- write data.
- busy  out  1  -- a reconfiguration is in progress.
- done  out  1  -- one-cycle pulse when the PLL has relocked.
- cur_pal  out  1  -- mode last applied.

Function
REQ-005 SHALL pass pal and pll_locked through 2-flop synchronizers before use.
REQ-006 SHALL start a reconfiguration when it is in IDLE and synced pal differs from cur_pal; cur_pal SHALL update to the requested mode when the sequence starts.
REQ-007 SHALL implement the states IDLE, WRITE, WAIT_LOCK and DONE.
- WRITE steps a 3-bit index 0..6 over a fixed write table.
- WRITE goes to WAIT_LOCK after index 6.
- WAIT_LOCK goes to DONE once synced pll_locked is 1.
- DONE goes to IDLE after one cycle.
REQ-008 The write table SHALL be, as (address, data):
- 0: (0x00, 0) -- waitrequest mode.
- 1: (0x04, 0x00000404) -- M counter.
- 2: (0x07, K_NTSC or K_PAL per cur_pal).
- 3: (0x05, 0x00020302) -- C0.
- 4: (0x05, 0x00040505) -- C1.
- 5: (0x05, 0x00080A0A) -- C2.
- 6: (0x02, 0) -- start.
REQ-009 C-counter data format SHALL be: [22:18] counter number, [17] odd-duty, [16] bypass, [15:8] hi, [7:0] lo.
REQ-010 Write handshake:
- cfg_write, cfg_address and cfg_writedata are registered and held stable while cfg_waitrequest=1.
- A write completes on a cycle with cfg_write=1 and cfg_waitrequest=0; the index advances on the next cycle.
- At least one idle cycle with cfg_write=0 separates consecutive writes.
REQ-011 busy SHALL be 1 in every state other than IDLE.
REQ-012 done SHALL be 1 only in DONE.
REQ-013 A pal change during busy SHALL be ignored until IDLE is reached, then SHALL be re-evaluated per REQ-006.
REQ-014 The controller SHALL never abandon a write that is mid-handshake, except on rst.

Reset
REQ-015 rst SHALL force the following on the next refclk edge:
- state IDLE, index 0.
- cfg_write=0, cfg_address=0, cfg_writedata=0.
- busy=0, done=0.
- synchronizers cleared.
- cur_pal=0, so a pal=1 request after reset triggers a PAL reconfiguration.
REQ-016 rst asserted mid-sequence SHALL abort immediately with no further writes.

Configuration
REQ-017 With PLL_CFG_RETRY_EN defined:
- WAIT_LOCK counts cycles.
- If the count reaches LOCK_TMO without lock, the controller returns to WRITE with index 0 and re-runs the full table.
- The counter clears on entry to WAIT_LOCK.
REQ-018 Without PLL_CFG_RETRY_EN, WAIT_LOCK SHALL wait indefinitely and no timeout counter SHALL be synthesized.

Verification
REQ-019 Release rst with pal=0 -> no writes, busy=0, cur_pal=0.
REQ-020 Set pal=1 with waitrequest=0 and locked=1 -> 7 writes matching REQ-008 in order, with K=K_PAL, then a one-cycle done pulse and cur_pal=1.
REQ-021 Hold waitrequest=1 for 5 cycles during write 3 -> address 0x05 and data 0x00020302 held stable, no index skip.
REQ-022 Toggle pal 1->0 during write 2 -> the current sequence completes, then a second sequence runs with K=K_NTSC.
REQ-023 Assert rst during write 4 -> cfg_write=0 the next cycle and state IDLE.
REQ-024 With PLL_CFG_RETRY_EN and LOCK_TMO=16, hold locked=0 -> after 16 cycles in WAIT_LOCK the writes restart at address 0x00.

Source files
------------

// File: rtl/pll_cfg_ctrl.sv
// pll_cfg_ctrl: PLL reconfiguration sequencer for NTSC/PAL video clocks.
// When the synchronised mode request differs from the mode last applied,
// the controller writes a fixed 7-entry table to the PLL reconfig slave.
// It then waits for relock and pulses done for one cycle.
// Optional feature macro: PLL_CFG_RETRY_EN. When it is defined, a lock-wait
// timeout re-runs the whole table if the PLL fails to relock within
// LOCK_TMO cycles.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for a mode change request
// S_WRITE    | issuing table writes; index 0..6, with an idle gap after each
// S_WAIT_LOCK| all writes done, waiting for synced pll_locked
// S_DONE     | one-cycle done pulse, then back to S_IDLE
module pll_cfg_ctrl #(
    parameter logic [31:0] K_NTSC   = 32'd2537930535,
    parameter logic [31:0] K_PAL    = 32'd2201376897,
    parameter int unsigned LOCK_TMO = 1048575
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        pal,
    input  logic        pll_locked,
    input  logic        cfg_waitrequest,
    output logic [5:0]  cfg_address,
    output logic        cfg_write,
    output logic [31:0] cfg_writedata,
    output logic        busy,
    output logic        done,
    output logic        cur_pal
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITE     = 2'd1;
    localparam logic [1:0] S_WAIT_LOCK = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    localparam logic [2:0] LAST_IDX = 3'd6;

    // A zero timeout would make the retry path fire before the PLL could relock.
    if (LOCK_TMO == 0) begin : g_tmo_check
        $error("pll_cfg_ctrl: LOCK_TMO must be non-zero");
    end

    logic [1:0] state;
    logic [2:0] idx;
    logic       wr_gap;
    logic       pal_meta, pal_sync;
    logic       lock_meta, lock_sync;
    logic       lock_timeout;

    // C-counter word: [22:18] counter, [17] odd duty, [16] bypass, [15:8] hi, [7:0] lo.
    function automatic logic [31:0] c_word(input logic [4:0] num, input logic odd,
                                           input logic byp, input logic [7:0] hi,
                                           input logic [7:0] lo);
        c_word = {9'd0, num, odd, byp, hi, lo};
    endfunction

    // Reconfig write table as {address, data}; only entry 2 depends on the mode.
    function automatic logic [37:0] table_entry(input logic [2:0] i, input logic mode_pal);
        case (i)
            3'd0:    table_entry = {6'h00, 32'h0000_0000};
            3'd1:    table_entry = {6'h04, 32'h0000_0404};
            3'd2:    table_entry = {6'h07, mode_pal ? K_PAL : K_NTSC};
            3'd3:    table_entry = {6'h05, c_word(5'd0, 1'b1, 1'b0, 8'd3, 8'd2)};
            3'd4:    table_entry = {6'h05, c_word(5'd1, 1'b0, 1'b0, 8'd5, 8'd5)};
            3'd5:    table_entry = {6'h05, c_word(5'd2, 1'b0, 1'b0, 8'd10, 8'd10)};
            default: table_entry = {6'h02, 32'h0000_0000};
        endcase
    endfunction

    // Two-flop synchronisers for the asynchronous mode request and lock status.
    always_ff @(posedge refclk) begin
        if (rst) begin
            pal_meta  <= 1'b0;
            pal_sync  <= 1'b0;
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            pal_meta  <= pal;
            pal_sync  <= pal_meta;
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

`ifdef PLL_CFG_RETRY_EN
    localparam int TMO_W = $clog2(LOCK_TMO + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Lock-wait cycle counter; held at zero outside S_WAIT_LOCK so every entry starts fresh.
    always_ff @(posedge refclk) begin
        if (rst || (state != S_WAIT_LOCK)) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign lock_timeout = (tmo_cnt == TMO_W'(LOCK_TMO - 1));
`else
    assign lock_timeout = 1'b0;
`endif

    // Sequencer FSM and registered reconfig bus.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= S_IDLE;
            idx           <= 3'd0;
            wr_gap        <= 1'b0;
            cfg_write     <= 1'b0;
            cfg_address   <= 6'd0;
            cfg_writedata <= 32'd0;
            cur_pal       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pal_sync != cur_pal) begin
                        cur_pal <= pal_sync;
                        idx     <= 3'd0;
                        wr_gap  <= 1'b0;
                        state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (cfg_write) begin
                        // Bus stays frozen while the slave stalls.
                        if (!cfg_waitrequest) begin
                            cfg_write <= 1'b0;
                            wr_gap    <= 1'b1;
                        end
                    end else if (wr_gap) begin
                        wr_gap <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= S_WAIT_LOCK;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        {cfg_address, cfg_writedata} <= table_entry(idx, cur_pal);
                        cfg_write <= 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_sync) begin
                        state <= S_DONE;
                    end else if (lock_timeout) begin
                        idx    <= 3'd0;
                        wr_gap <= 1'b0;
                        state  <= S_WRITE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// tb_pll_cfg_ctrl: table-driven and randomised bench for pll_cfg_ctrl.
module tb_pll_cfg_ctrl;

    localparam logic [31:0] K_NTSC = 32'd2537930535;
    localparam logic [31:0] K_PAL  = 32'd2201376897;
`ifdef PLL_CFG_RETRY_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 1048575;
`endif

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        pal = 1'b0;
    logic        pll_locked = 1'b1;
    logic        cfg_waitrequest = 1'b0;
    logic [5:0]  cfg_address;
    logic        cfg_write;
    logic [31:0] cfg_writedata;
    logic        busy;
    logic        done;
    logic        cur_pal;

    always #10 refclk = ~refclk;

    pll_cfg_ctrl #(
        .K_NTSC   (K_NTSC),
        .K_PAL    (K_PAL),
        .LOCK_TMO (TMO)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .pal             (pal),
        .pll_locked      (pll_locked),
        .cfg_waitrequest (cfg_waitrequest),
        .cfg_address     (cfg_address),
        .cfg_write       (cfg_write),
        .cfg_writedata   (cfg_writedata),
        .busy            (busy),
        .done            (done),
        .cur_pal         (cur_pal)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [37:0] wr_log[$];
    logic [37:0] exp_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected write for table position i in the given mode, as {address, data}.
    function automatic logic [37:0] ref_write(input int i, input logic mode_pal);
        logic [5:0]  addr [0:6];
        logic [31:0] data [0:6];
        addr = '{6'h00, 6'h04, 6'h07, 6'h05, 6'h05, 6'h05, 6'h02};
        data = '{32'h0, 32'h0000_0404, (mode_pal ? K_PAL : K_NTSC),
                 32'h0002_0302, 32'h0004_0505, 32'h0008_0A0A, 32'h0};
        return {addr[i], data[i]};
    endfunction

    task automatic push_table(input logic mode_pal);
        for (int i = 0; i < 7; i++) exp_log.push_back(ref_write(i, mode_pal));
    endtask

    task automatic compare_logs(input string name);
        int n;
        check($sformatf("%s_write_count", name), wr_log.size(), exp_log.size());
        n = (wr_log.size() < exp_log.size()) ? wr_log.size() : exp_log.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_write%0d", name, i), wr_log[i], exp_log[i]);
        end
        wr_log.delete();
        exp_log.delete();
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int start;
        int k;
        start = done_cnt;
        k = 0;
        while (done_cnt == start && k < budget) begin
            tick();
            k++;
        end
        check($sformatf("%s_done_seen", name), done_cnt - start, 1);
    endtask

    // Bus monitor: logs completed writes and checks hold / gap / pulse rules.
    logic        prev_stall = 1'b0;
    logic        prev_complete = 1'b0;
    logic        prev_done = 1'b0;
    logic [5:0]  prev_a = '0;
    logic [31:0] prev_d = '0;

    always @(negedge refclk) begin
        if (rst) begin
            prev_stall    = 1'b0;
            prev_complete = 1'b0;
            prev_done     = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_write", cfg_write, 1);
                check("hold_addr", cfg_address, prev_a);
                check("hold_data", cfg_writedata, prev_d);
            end
            if (prev_complete) check("gap_after_write", cfg_write, 0);
            if (prev_done) check("done_one_cycle", done, 0);
            if (cfg_write) check("busy_while_write", busy, 1);
            if (done) begin
                check("busy_in_done", busy, 1);
                done_cnt++;
            end
            if (cfg_write && !cfg_waitrequest) wr_log.push_back({cfg_address, cfg_writedata});
            prev_stall    = cfg_write && cfg_waitrequest;
            prev_complete = cfg_write && !cfg_waitrequest;
            prev_done     = done;
            prev_a        = cfg_address;
            prev_d        = cfg_writedata;
        end
    end

    typedef struct {
        logic req_pal;
        int   stall_idx;
        int   stall_len;
    } vec_t;

    vec_t        vecs[4];
    logic [37:0] ew;
    logic        model_cur;
    logic        tgt;
    int          lock_dly;
    int          lock_wait;
    int          start;
    int          k;
    bit          seen_busy;
    int          gap;

    initial begin
        vecs[0] = '{1'b1, 7, 0};
        vecs[1] = '{1'b0, 3, 5};
        vecs[2] = '{1'b1, 2, 3};
        vecs[3] = '{1'b0, 0, 1};

        // Reset, then release with pal=0: nothing should happen.
        rst = 1'b1;
        repeat (3) tick();
        check("rst_cfg_write", cfg_write, 0);
        check("rst_cfg_address", cfg_address, 0);
        check("rst_cfg_writedata", cfg_writedata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cur_pal", cur_pal, 0);
        rst = 1'b0;
        repeat (20) tick();
        check("idle_busy", busy, 0);
        check("idle_cfg_write", cfg_write, 0);
        check("idle_cur_pal", cur_pal, 0);
        check("idle_no_writes", wr_log.size(), 0);

        // Table-driven mode changes with an optional stall on one write.
        for (int v = 0; v < 4; v++) begin
            pal = vecs[v].req_pal;
            push_table(vecs[v].req_pal);
            start = done_cnt;
            k = 0;
            seen_busy = 0;
            while (done_cnt == start && k < 400) begin
                tick();
                k++;
                if (busy && !seen_busy) begin
                    seen_busy = 1;
                    check("vec_cur_pal_at_start", cur_pal, vecs[v].req_pal);
                end
                if (cfg_write && vecs[v].stall_len > 0 && wr_log.size() == vecs[v].stall_idx) begin
                    ew = ref_write(vecs[v].stall_idx, vecs[v].req_pal);
                    cfg_waitrequest = 1'b1;
                    for (int s = 0; s < vecs[v].stall_len; s++) begin
                        tick();
                        check("stall_write", cfg_write, 1);
                        check("stall_addr", cfg_address, ew[37:32]);
                        check("stall_data", cfg_writedata, ew[31:0]);
                    end
                    cfg_waitrequest = 1'b0;
                end
            end
            check($sformatf("vec%0d_done_seen", v), done_cnt - start, 1);
            check($sformatf("vec%0d_cur_pal", v), cur_pal, vecs[v].req_pal);
            tick();
            check($sformatf("vec%0d_busy_after", v), busy, 0);
            compare_logs($sformatf("vec%0d", v));
        end

        // Mode flips back during write 2: current run completes, then an NTSC run.
        pal = 1'b1;
        push_table(1'b1);
        push_table(1'b0);
        k = 0;
        while (!(cfg_write && wr_log.size() == 2) && k < 200) begin
            tick();
            k++;
        end
        check("toggle_reached_write2", (cfg_write && wr_log.size() == 2), 1);
        pal = 1'b0;
        wait_done(400, "toggle_first");
        wait_done(400, "toggle_second");
        tick();
        check("toggle_cur_pal", cur_pal, 0);
        check("toggle_busy_after", busy, 0);
        compare_logs("toggle");

        // Reset during write 4 aborts with no further writes.
        pal = 1'b1;
        for (int i = 0; i < 4; i++) exp_log.push_back(ref_write(i, 1'b1));
        k = 0;
        while (!(cfg_write && wr_log.size() == 4) && k < 200) begin
            tick();
            k++;
        end
        check("abort_reached_write4", (cfg_write && wr_log.size() == 4), 1);
        rst = 1'b1;
        pal = 1'b0;
        tick();
        check("abort_cfg_write", cfg_write, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_cur_pal", cur_pal, 0);
        check("abort_cfg_address", cfg_address, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (15) tick();
        check("abort_still_idle", busy, 0);
        compare_logs("abort");

        // Randomised requests, stalls and lock delay against the mode model.
        model_cur = 1'b0;
        for (int it = 0; it < 16; it++) begin
            tgt = 1'($urandom_range(0, 1));
            lock_dly = $urandom_range(0, 8);
            pal = tgt;
            if (tgt != model_cur) begin
                push_table(tgt);
                model_cur = tgt;
                pll_locked = 1'b0;
                lock_wait = 0;
                start = done_cnt;
                k = 0;
                while (done_cnt == start && k < 800) begin
                    tick();
                    k++;
                    cfg_waitrequest = ($urandom_range(0, 2) == 0);
                    if (!pll_locked && wr_log.size() == 7) begin
                        if (lock_wait == lock_dly) begin
                            check("rand_no_done_before_lock", done_cnt - start, 0);
                            pll_locked = 1'b1;
                        end else begin
                            lock_wait++;
                        end
                    end
                end
                check($sformatf("rand%0d_done_seen", it), done_cnt - start, 1);
            end else begin
                for (int c = 0; c < 30; c++) begin
                    tick();
                    cfg_waitrequest = ($urandom_range(0, 2) == 0);
                end
            end
            pll_locked = 1'b1;
            cfg_waitrequest = 1'b0;
            tick();
            check($sformatf("rand%0d_cur_pal", it), cur_pal, model_cur);
            check($sformatf("rand%0d_busy", it), busy, 0);
            compare_logs($sformatf("rand%0d", it));
        end

`ifdef PLL_CFG_RETRY_EN
        // No lock: the full table is re-run after the lock-wait timeout.
        tgt = ~model_cur;
        pal = tgt;
        push_table(tgt);
        push_table(tgt);
        pll_locked = 1'b0;
        k = 0;
        while (wr_log.size() < 7 && k < 400) begin
            tick();
            k++;
        end
        tick();
        gap = 0;
        k = 0;
        while (!cfg_write && k < 100) begin
            gap++;
            tick();
            k++;
        end
        check("retry_gap_in_range", (gap >= 16 && gap <= 20), 1);
        k = 0;
        while (wr_log.size() < 14 && k < 400) begin
            tick();
            k++;
        end
        pll_locked = 1'b1;
        wait_done(100, "retry");
        tick();
        check("retry_cur_pal", cur_pal, tgt);
        compare_logs("retry");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
